// File: rtl/rnd_bcd_display.sv
// rnd_bcd_display: captures an LFSR byte on step, converts it to three
// BCD digits with a shift-per-clock double-dabble, drives 7-seg patterns.
// Ports: clk, rst (sync, active-high), rnd_in[7:0], step -> busy, done,
//        bcd[11:0] {hundreds,tens,units}, seg2/seg1/seg0 {g,f,e,d,c,b,a}.
module rnd_bcd_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rnd_in,
    input  logic        step,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd,
    output logic [6:0]  seg2,
    output logic [6:0]  seg1,
    output logic [6:0]  seg0
);

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    state_t      state;
    logic [7:0]  shreg;
    logic [11:0] scratch;
    logic [2:0]  cnt;

    logic [11:0] adj;
    logic        blank_h;
    logic        blank_t;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Table is active-low; flipped once at the end for active-high boards.
    function automatic logic [6:0] seg_enc(input logic [3:0] d,
                                           input logic       blank);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        if (blank)
            p = 7'h7F;
        return SEG_ACTIVE_LOW ? p : ~p;
    endfunction

    // All three nibbles are corrected on their pre-shift values.
    always_comb begin
        adj     = {add3(scratch[11:8]), add3(scratch[7:4]), add3(scratch[3:0])};
        blank_h = BLANK_LZ && (scratch[11:8] == 4'd0);
        blank_t = blank_h && (scratch[7:4] == 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= 12'h000;
            seg2    <= SEG_OFF;
            seg1    <= SEG_OFF;
            seg0    <= SEG_OFF;
            shreg   <= 8'h00;
            scratch <= 12'h000;
            cnt     <= 3'd0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (step) begin
                        shreg   <= rnd_in;
                        scratch <= 12'h000;
                        cnt     <= 3'd0;
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    scratch <= {adj[10:0], shreg[7]};
                    shreg   <= {shreg[6:0], 1'b0};
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= LOAD;
                end
                LOAD: begin
                    bcd   <= scratch;
                    seg2  <= seg_enc(scratch[11:8], blank_h);
                    seg1  <= seg_enc(scratch[7:4], blank_t);
                    seg0  <= seg_enc(scratch[3:0], 1'b0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rnd_bcd_display.sv
// tb_rnd_bcd_display: random + directed stimulus against a decimal model.
// Outputs are compared every cycle; directed cases pin literal values.
module tb_rnd_bcd_display;

    localparam bit AL = 1'b1;
    localparam bit BL = 1'b1;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        step   = 1'b0;
    logic [7:0]  rnd_in = 8'h00;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg2;
    logic [6:0]  seg1;
    logic [6:0]  seg0;

    rnd_bcd_display #(
        .SEG_ACTIVE_LOW(AL),
        .BLANK_LZ      (BL)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rnd_in(rnd_in),
        .step  (step),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .seg2  (seg2),
        .seg1  (seg1),
        .seg0  (seg0)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [6:0] exp_seg(input int d, input bit blank);
        logic [6:0] p;
        case (d)
            0: p = 7'h40;
            1: p = 7'h79;
            2: p = 7'h24;
            3: p = 7'h30;
            4: p = 7'h19;
            5: p = 7'h12;
            6: p = 7'h02;
            7: p = 7'h78;
            8: p = 7'h00;
            default: p = 7'h10;
        endcase
        if (blank)
            p = 7'h7F;
        return AL ? p : ~p;
    endfunction

    // Model: a conversion is just "cycles left until the result appears".
    int          m_left = 0;
    bit          m_done = 1'b0;
    int          m_val  = 0;
    logic [11:0] m_bcd  = 12'h000;
    logic [6:0]  m_s2   = 7'h7F;
    logic [6:0]  m_s1   = 7'h7F;
    logic [6:0]  m_s0   = 7'h7F;
    int          mh, mt, mu;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_bcd  = 12'h000;
            m_s2   = exp_seg(0, 1'b1);
            m_s1   = exp_seg(0, 1'b1);
            m_s0   = exp_seg(0, 1'b1);
        end else begin
            m_done = 1'b0;
            if (m_left == 0 && step) begin
                m_left = 9;
                m_val  = int'(rnd_in);
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    mh     = m_val / 100;
                    mt     = (m_val / 10) % 10;
                    mu     = m_val % 10;
                    m_done = 1'b1;
                    m_bcd  = {mh[3:0], mt[3:0], mu[3:0]};
                    m_s2   = exp_seg(mh, BL && mh == 0);
                    m_s1   = exp_seg(mt, BL && mh == 0 && mt == 0);
                    m_s0   = exp_seg(mu, 1'b0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_left != 0));
            check("done", 32'(done), 32'(m_done));
            check("bcd", 32'(bcd), 32'(m_bcd));
            check("seg2", 32'(seg2), 32'(m_s2));
            check("seg1", 32'(seg1), 32'(m_s1));
            check("seg0", 32'(seg0), 32'(m_s0));
        end
    end

    task automatic conv(input logic [7:0] v, output int lat, output int bcyc);
        rnd_in = v;
        step   = 1'b1;
        lat    = 0;
        bcyc   = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1)
                step = 1'b0;
            if (busy)
                bcyc++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic segs_are(input string tag, input logic [6:0] e2,
                            input logic [6:0] e1, input logic [6:0] e0);
        check({tag, "_seg2"}, 32'(seg2), 32'(e2));
        check({tag, "_seg1"}, 32'(seg1), 32'(e1));
        check({tag, "_seg0"}, 32'(seg0), 32'(e0));
    endtask

    int lat;
    int bcyc;
    int dones;

    initial begin
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'h000);
        segs_are("rst", 7'h7F, 7'h7F, 7'h7F);

        conv(8'd255, lat, bcyc);
        check("lat255", lat, 10);
        check("busy255", bcyc, 9);
        check("bcd255", 32'(bcd), 32'h255);
        segs_are("v255", 7'h24, 7'h12, 7'h12);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);

        conv(8'd0, lat, bcyc);
        check("lat0", lat, 10);
        check("bcd0", 32'(bcd), 32'h000);
        segs_are("v0", 7'h7F, 7'h7F, 7'h40);

        conv(8'd100, lat, bcyc);
        check("bcd100", 32'(bcd), 32'h100);
        segs_are("v100", 7'h79, 7'h40, 7'h40);
        conv(8'd7, lat, bcyc);
        check("bcd7", 32'(bcd), 32'h007);
        segs_are("v7", 7'h7F, 7'h7F, 7'h78);

        rnd_in = 8'd42;
        step   = 1'b1;
        dones  = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1)
                step = 1'b0;
            if (n == 3) begin
                rnd_in = 8'd99;
                step   = 1'b1;
            end
            if (n == 4)
                step = 1'b0;
            if (done)
                dones++;
        end
        check("ign_dones", dones, 1);
        check("bcd42", 32'(bcd), 32'h042);
        segs_are("v42", 7'h7F, 7'h19, 7'h24);

        rnd_in = 8'd200;
        step   = 1'b1;
        dones  = 0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1)
                step = 1'b0;
            if (n == 4)
                rst = 1'b1;
            if (n == 5)
                rst = 1'b0;
            if (done)
                dones++;
        end
        check("abort_dones", dones, 0);
        check("abort_bcd", 32'(bcd), 32'h000);
        segs_are("abort", 7'h7F, 7'h7F, 7'h7F);
        conv(8'd200, lat, bcyc);
        check("lat200", lat, 10);
        check("bcd200", 32'(bcd), 32'h200);
        segs_are("v200", 7'h24, 7'h40, 7'h40);

        step  = 1'b1;
        dones = 0;
        for (int n = 1; n <= 40; n++) begin
            rnd_in = 8'($urandom);
            @(negedge clk);
            if (done)
                dones++;
        end
        step = 1'b0;
        check("b2b_dones", dones, 4);
        repeat (12) @(negedge clk);

        for (int n = 0; n < 600; n++) begin
            step   = ($urandom_range(3) == 0);
            rnd_in = 8'($urandom);
            rst    = ($urandom_range(96) == 0);
            @(negedge clk);
        end
        rst  = 1'b0;
        step = 1'b0;
        repeat (12) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rnd_bcd_display.md
Name: rnd_bcd_display

Overview:
- Downstream consumer of the 8-bit LFSR pseudo-random generator.
- On a step request it captures the current random byte and converts it to three decimal digits with a sequential double-dabble engine, one shift per clock.
- It then drives three registered 7-segment digit patterns (hundreds, tens, units) for the board's seven-segment display.
- Between requests, the displayed value holds stable while the LFSR keeps running.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its bit is 0 (board default); 0 = lit when 1.
- BLANK_LZ, 1, 1 = blank leading-zero hundreds/tens digits; the units digit is never blanked.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
- rnd_in  input  8  random byte from the LFSR, sampled only on capture.
- step  input  1  capture/convert request, level-sampled each cycle.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when new digits appear on the outputs.
- bcd  output  12  registered result: [11:8] hundreds, [7:4] tens, [3:0] units.
- seg2  output  7  hundreds digit pattern, bit order {g,f,e,d,c,b,a}.
- seg1  output  7  tens digit pattern.
- seg0  output  7  units digit pattern.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over everything else.
- Reset values:
  - state = IDLE, busy = 0, done = 0, bcd = 12'h000.
  - seg2/seg1/seg0 = all segments off: 7'h7F if SEG_ACTIVE_LOW, else 7'h00.
  - Internal shift register and iteration counter = 0.
- FSM states: IDLE, CONV, LOAD.
- IDLE:
  - If step = 1: latch rnd_in into an 8-bit shift register, clear a 12-bit scratch BCD, set counter = 0, go to CONV.
  - Otherwise stay in IDLE.
- CONV, one iteration per cycle:
  - For each scratch nibble >= 5, add 3. All three nibbles are corrected in parallel on pre-shift values.
  - Then shift {scratch, shreg} left by 1.
  - Counter increments. After the 8th iteration (counter reaches 7 during the update), go to LOAD.
- LOAD:
  - Copy scratch to bcd.
  - Encode each digit into seg2/seg1/seg0 and assert done for exactly one cycle.
  - Return to IDLE.
- Latency:
  - step sampled at edge k; CONV iterations at edges k+1..k+8; LOAD completes at edge k+9.
  - New outputs and done = 1 are visible in the cycle after edge k+9.
  - busy = 1 during the cycles after edges k..k+8.
- Segment encoding (active-low values; invert all 7 bits when SEG_ACTIVE_LOW = 0):
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 10 (hex).
  - Blank = 7F.
- Blanking (BLANK_LZ = 1):
  - Hundreds is blank when hundreds = 0.
  - Tens is blank when hundreds = 0 and tens = 0.
  - Units is never blanked.
  - bcd is never blanked.
- Boundary conditions:
  - step while busy is ignored; no queuing, no restart.
  - step held high continuously: back-to-back conversions, one capture per return to IDLE. Each conversion recaptures rnd_in in the IDLE cycle, so the period is 10 cycles.
  - rnd_in changing during CONV has no effect.
  - rst during CONV or LOAD aborts the conversion: outputs return to reset values, no done pulse.
  - Maximum input 255 gives hundreds = 2. No nibble ever exceeds 9.
  - Outputs hold their last values indefinitely in IDLE.

Test Plan:
- Reset, then idle for 5 cycles -> busy = 0, done = 0, bcd = 000, seg2/seg1/seg0 = 7F/7F/7F.
- rnd_in = 8'd255, step pulse -> done exactly 10 cycles after the step edge; bcd = 12'h255; seg2/seg1/seg0 = 24/12/12; busy high for 9 cycles.
- rnd_in = 8'd0, step (BLANK_LZ = 1) -> bcd = 000; segs = 7F/7F/40.
- rnd_in = 8'd100 then 8'd7, sequential steps -> 100 gives 79/40/40; 7 gives 7F/7F/78.
- Hold rnd_in = 8'd42, step at cycle 0, change rnd_in to 8'd99 and pulse step again at cycle 3 -> only one done pulse; bcd = 12'h042; segs = 7F/19/24.
- step with rnd_in = 8'd200, assert rst at cycle 4 -> no done pulse; outputs return to reset values; a subsequent step with 8'd200 yields bcd = 12'h200 after 10 cycles.
